// File: rtl/seven_seg_scan_rx_pkg.sv
// Shared definitions for the 7-segment scan receiver: the active-low glyph table
// (single source of truth for encoder and receiver) and the decode result type.
package seven_seg_scan_rx_pkg;

  // Active-low patterns, bit6=g ... bit0=a; entry i is the glyph for hex value i.
  localparam logic [15:0][6:0] SEG_PAT = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef struct packed {
    logic       legal;
    logic       blank;
    logic [3:0] nib;
  } seg_dec_t;

endpackage

// File: rtl/seven_seg_scan_rx_if.sv
// Event stream port of the scan receiver: one {digit, value} per accepted transfer.
interface seven_seg_scan_rx_if #(
  parameter int DIG_W = 2
);
  logic             evt_valid;
  logic [DIG_W-1:0] evt_digit;
  logic [3:0]       evt_num;
  logic             evt_ready;

  modport master (output evt_valid, output evt_digit, output evt_num, input evt_ready);
  modport slave  (input evt_valid, input evt_digit, input evt_num, output evt_ready);
endinterface

// File: rtl/seven_seg_pattern_decode.sv
// Combinational 7-segment pattern to hex decoder; flags blank and illegal glyphs.
module seven_seg_pattern_decode
  import seven_seg_scan_rx_pkg::*;
(
  input  logic [6:0] seg,
  output seg_dec_t   dec
);

  // Table match against the 16 legal glyphs.
  always_comb begin
    dec.legal = 1'b0;
    dec.blank = (seg == SEG_BLANK);
    dec.nib   = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG_PAT[4'(i)]) begin
        dec.legal = 1'b1;
        dec.nib   = 4'(i);
      end else begin
        dec.legal = dec.legal;
      end
    end
  end

endmodule

// File: rtl/seven_seg_scan_rx.sv
// Receive side of a multiplexed 7-segment bus: synchronise, settle, sample once per
// strobe, debounce per digit, decode, and stream changed digits over a valid/ready slot.
module seven_seg_scan_rx
  import seven_seg_scan_rx_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DIG_W      = 2,
  parameter int SETTLE     = 2,
  parameter int STABLE_CNT = 3
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [6:0]              seg,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  output logic [4*NUM_DIGITS-1:0] num,
  output logic [NUM_DIGITS-1:0]   valid_mask,
  output logic [NUM_DIGITS-1:0]   err_mask,
  output logic                    sel_err,
  seven_seg_scan_rx_if.master     evt
);

  // Dwell saturates one past SETTLE so a held strobe is sampled exactly once.
  localparam int                 DWELL_W   = $clog2(SETTLE + 2);
  localparam logic [DWELL_W-1:0] DWELL_SAT = DWELL_W'(SETTLE + 1);
  localparam logic [DWELL_W-1:0] DWELL_HIT = DWELL_W'(SETTLE);
  localparam logic [3:0]         CNT_MAX   = 4'(STABLE_CNT);

  logic [6:0]                      seg_meta_r, seg_sync_r;
  logic [NUM_DIGITS-1:0]           dig_meta_r, dig_sync_r, dig_prev_r;
  logic [DWELL_W-1:0]              dwell_r, dwell_nxt_s;
  logic                            sample_s, multi_hot_s, good_sample_s;
  logic [NUM_DIGITS-1:0][6:0]      cand_r;
  logic [NUM_DIGITS-1:0][3:0]      cnt_r, num_r;
  logic [NUM_DIGITS-1:0]           valid_r, err_r, pend_r;
  logic [NUM_DIGITS-1:0]           hit_s, match_s, commit_s, pend_set_s, pend_clr_s;
  logic                            sel_err_r;
  seg_dec_t                        dec_s;
  logic [DIG_W-1:0]                ptr_r, pick_s;
  logic                            found_s, load_s;
  logic                            evt_valid_r;
  logic [DIG_W-1:0]                evt_digit_r;
  logic [3:0]                      evt_num_r;

  // Two-flop synchroniser for the segment and strobe lines.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_meta_r <= SEG_BLANK;
      seg_sync_r <= SEG_BLANK;
      dig_meta_r <= '0;
      dig_sync_r <= '0;
    end else begin
      seg_meta_r <= seg;
      seg_sync_r <= seg_meta_r;
      dig_meta_r <= dig_sel;
      dig_sync_r <= dig_meta_r;
    end
  end

  // Dwell counting and sample qualification.
  always_comb begin
    if (dig_sync_r != dig_prev_r) begin
      dwell_nxt_s = DWELL_W'(1);
    end else if (dwell_r != DWELL_SAT) begin
      dwell_nxt_s = dwell_r + DWELL_W'(1);
    end else begin
      dwell_nxt_s = dwell_r;
    end
    multi_hot_s   = (dig_sync_r & (dig_sync_r - NUM_DIGITS'(1))) != '0;
    sample_s      = (dwell_nxt_s == DWELL_HIT) && (dig_sync_r != '0);
    good_sample_s = sample_s && !multi_hot_s;
  end

  // Dwell state and sticky strobe error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dig_prev_r <= '0;
      dwell_r    <= '0;
      sel_err_r  <= 1'b0;
    end else begin
      dig_prev_r <= dig_sync_r;
      dwell_r    <= dwell_nxt_s;
      if (sample_s && multi_hot_s) begin
        sel_err_r <= 1'b1;
      end
    end
  end

  seven_seg_pattern_decode u_decode (
    .seg (seg_sync_r),
    .dec (dec_s)
  );

  // Per-digit debounce match and commit detection; commit fires only on reaching the limit.
  always_comb begin
    for (int d = 0; d < NUM_DIGITS; d++) begin
      hit_s[d]      = good_sample_s && dig_sync_r[d];
      match_s[d]    = (seg_sync_r == cand_r[d]);
      commit_s[d]   = hit_s[d] && (match_s[d] ? (cnt_r[d] == CNT_MAX - 4'd1)
                                              : (CNT_MAX == 4'd1));
      pend_set_s[d] = commit_s[d] && dec_s.legal &&
                      (!valid_r[d] || (num_r[d] != dec_s.nib));
    end
  end

  // Round-robin pick of the next pending digit, starting at the pointer.
  always_comb begin
    found_s = 1'b0;
    pick_s  = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!found_s && pend_r[DIG_W'((int'(ptr_r) + i) % NUM_DIGITS)]) begin
        found_s = 1'b1;
        pick_s  = DIG_W'((int'(ptr_r) + i) % NUM_DIGITS);
      end else begin
        found_s = found_s;
      end
    end
    load_s     = found_s && (!evt_valid_r || evt.evt_ready);
    pend_clr_s = load_s ? (NUM_DIGITS'(1) << pick_s) : '0;
  end

  // Candidate/count tracking, committed value state and pending flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cand_r  <= {NUM_DIGITS{SEG_BLANK}};
      cnt_r   <= '0;
      num_r   <= '0;
      valid_r <= '0;
      err_r   <= '0;
      pend_r  <= '0;
    end else begin
      for (int d = 0; d < NUM_DIGITS; d++) begin
        if (hit_s[d]) begin
          if (!match_s[d]) begin
            cand_r[d] <= seg_sync_r;
            cnt_r[d]  <= 4'd1;
          end else if (cnt_r[d] != CNT_MAX) begin
            cnt_r[d] <= cnt_r[d] + 4'd1;
          end
        end
        if (commit_s[d]) begin
          if (dec_s.legal) begin
            num_r[d]   <= dec_s.nib;
            valid_r[d] <= 1'b1;
            err_r[d]   <= 1'b0;
          end else begin
            valid_r[d] <= 1'b0;
            err_r[d]   <= !dec_s.blank;
          end
        end
      end
      // A commit in the same cycle as a load re-arms the digit.
      pend_r <= (pend_r & ~pend_clr_s) | pend_set_s;
    end
  end

  // Event output slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      evt_valid_r <= 1'b0;
      evt_digit_r <= '0;
      evt_num_r   <= 4'h0;
      ptr_r       <= '0;
    end else if (load_s) begin
      evt_valid_r <= 1'b1;
      evt_digit_r <= pick_s;
      evt_num_r   <= num_r[pick_s];
      ptr_r       <= (int'(pick_s) == NUM_DIGITS - 1) ? '0 : pick_s + DIG_W'(1);
    end else if (evt.evt_ready) begin
      evt_valid_r <= 1'b0;
    end
  end

  assign num           = num_r;
  assign valid_mask    = valid_r;
  assign err_mask      = err_r;
  assign sel_err       = sel_err_r;
  assign evt.evt_valid = evt_valid_r;
  assign evt.evt_digit = evt_digit_r;
  assign evt.evt_num   = evt_num_r;

endmodule

// File: tb/tb_seven_seg_scan_rx.sv
// Directed bench for seven_seg_scan_rx: frames of strobed digits, event capture queue,
// hand-computed expectations per scenario.
module tb_seven_seg_scan_rx;

  localparam logic [6:0] P1 = 7'h79, P2 = 7'h24, P3 = 7'h30, P4 = 7'h19;
  localparam logic [6:0] P5 = 7'h12, P7 = 7'h78, P9 = 7'h10, PA = 7'h08;
  localparam logic [6:0] BL = 7'h7F;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [6:0]  seg = 7'h7F;
  logic [3:0]  dig_sel = 4'h0;
  logic [15:0] num;
  logic [3:0]  valid_mask, err_mask;
  logic        sel_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [5:0] evq[$];
  int         evc[$];

  seven_seg_scan_rx_if #(.DIG_W(2)) evt_if ();

  seven_seg_scan_rx #(
    .NUM_DIGITS (4),
    .DIG_W      (2),
    .SETTLE     (2),
    .STABLE_CNT (3)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .seg        (seg),
    .dig_sel    (dig_sel),
    .num        (num),
    .valid_mask (valid_mask),
    .err_mask   (err_mask),
    .sel_err    (sel_err),
    .evt        (evt_if.master)
  );

  always #5 clk = ~clk;

  // Record every accepted transfer with its cycle stamp.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (reset_n && evt_if.evt_valid && evt_if.evt_ready) begin
      evq.push_back({evt_if.evt_digit, evt_if.evt_num});
      evc.push_back(cyc);
    end
  end

  task automatic drive(input logic [3:0] sel, input logic [6:0] pat, input int n);
    dig_sel = sel;
    seg     = pat;
    repeat (n) @(negedge clk);
  endtask

  task automatic idle(input int n);
    drive(4'b0000, BL, n);
  endtask

  task automatic frame(input logic [6:0] p0, input logic [6:0] p1,
                       input logic [6:0] p2, input logic [6:0] p3);
    drive(4'b0001, p0, 4);
    drive(4'b0010, p1, 4);
    drive(4'b0100, p2, 4);
    drive(4'b1000, p3, 4);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    dig_sel = 4'h0;
    seg     = BL;
    evt_if.evt_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    evq.delete();
    evc.delete();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    evt_if.evt_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (num !== 16'h0000) begin errors++; $display("FAIL reset_num got %h want %h", num, 16'h0000); end
    checks++; if (valid_mask !== 4'h0) begin errors++; $display("FAIL reset_valid got %h want %h", valid_mask, 4'h0); end
    checks++; if (err_mask !== 4'h0) begin errors++; $display("FAIL reset_err got %h want %h", err_mask, 4'h0); end
    checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL reset_sel_err got %b want 0", sel_err); end
    checks++; if (evt_if.evt_valid !== 1'b0) begin errors++; $display("FAIL reset_evt_valid got %b want 0", evt_if.evt_valid); end
    checks++; if (evt_if.evt_digit !== 2'd0) begin errors++; $display("FAIL reset_evt_digit got %0d want 0", evt_if.evt_digit); end
    checks++; if (evt_if.evt_num !== 4'h0) begin errors++; $display("FAIL reset_evt_num got %h want 0", evt_if.evt_num); end
    reset_n = 1'b1;
    idle(6);
    checks++; if (evt_if.evt_valid !== 1'b0) begin errors++; $display("FAIL reset_idle_evt got %b want 0", evt_if.evt_valid); end
  endtask

  task automatic test_decode_frames();
    logic [5:0] e, got;
    do_reset();
    repeat (3) frame(P1, P2, P3, P4);
    idle(8);
    checks++; if (num !== 16'h4321) begin errors++; $display("FAIL frames_num got %h want %h", num, 16'h4321); end
    checks++; if (valid_mask !== 4'hF) begin errors++; $display("FAIL frames_valid got %h want %h", valid_mask, 4'hF); end
    checks++; if (err_mask !== 4'h0) begin errors++; $display("FAIL frames_err got %h want %h", err_mask, 4'h0); end
    checks++; if (evq.size() !== 4) begin errors++; $display("FAIL frames_evt_count got %0d want 4", evq.size()); end
    for (int i = 0; i < 4; i++) begin
      e   = {2'(i), 4'(i + 1)};
      got = (i < evq.size()) ? evq[i] : 6'h3F;
      checks++; if (got !== e) begin errors++; $display("FAIL frames_evt%0d got %h want %h", i, got, e); end
    end
    checks++; if (evt_if.evt_valid !== 1'b0) begin errors++; $display("FAIL frames_evt_drop got %b want 0", evt_if.evt_valid); end
    frame(P1, P2, P3, P4);
    idle(8);
    checks++; if (evq.size() !== 4) begin errors++; $display("FAIL frames_no_repeat got %0d want 4", evq.size()); end
  endtask

  task automatic test_glitch();
    logic [5:0] got;
    do_reset();
    repeat (2) frame(BL, BL, P2, BL);
    frame(BL, BL, 7'h7E, BL);
    idle(6);
    checks++; if (valid_mask[2] !== 1'b0) begin errors++; $display("FAIL glitch_valid got %b want 0", valid_mask[2]); end
    checks++; if (err_mask[2] !== 1'b0) begin errors++; $display("FAIL glitch_err got %b want 0", err_mask[2]); end
    repeat (2) frame(BL, BL, P2, BL);
    idle(6);
    checks++; if (valid_mask[2] !== 1'b0) begin errors++; $display("FAIL glitch_early got %b want 0", valid_mask[2]); end
    frame(BL, BL, P2, BL);
    idle(8);
    checks++; if (valid_mask !== 4'b0100) begin errors++; $display("FAIL glitch_commit got %b want 0100", valid_mask); end
    checks++; if (num[11:8] !== 4'h2) begin errors++; $display("FAIL glitch_num got %h want 2", num[11:8]); end
    checks++; if (err_mask !== 4'h0) begin errors++; $display("FAIL glitch_err2 got %b want 0000", err_mask); end
    got = (evq.size() > 0) ? evq[0] : 6'h3F;
    checks++; if (evq.size() !== 1) begin errors++; $display("FAIL glitch_evt_count got %0d want 1", evq.size()); end
    checks++; if (got !== 6'b10_0010) begin errors++; $display("FAIL glitch_evt got %h want %h", got, 6'b10_0010); end
  endtask

  task automatic test_blank_illegal();
    do_reset();
    repeat (3) frame(P1, P2, P3, P4);
    idle(8);
    evq.delete();
    repeat (3) frame(P1, BL, P3, P4);
    idle(8);
    checks++; if (valid_mask !== 4'b1101) begin errors++; $display("FAIL blank_valid got %b want 1101", valid_mask); end
    checks++; if (err_mask !== 4'b0000) begin errors++; $display("FAIL blank_err got %b want 0000", err_mask); end
    checks++; if (num !== 16'h4321) begin errors++; $display("FAIL blank_num got %h want 4321", num); end
    checks++; if (evq.size() !== 0) begin errors++; $display("FAIL blank_evt got %0d want 0", evq.size()); end
    repeat (3) frame(P1, 7'h55, P3, P4);
    idle(8);
    checks++; if (err_mask !== 4'b0010) begin errors++; $display("FAIL illegal_err got %b want 0010", err_mask); end
    checks++; if (valid_mask !== 4'b1101) begin errors++; $display("FAIL illegal_valid got %b want 1101", valid_mask); end
    checks++; if (num[7:4] !== 4'h2) begin errors++; $display("FAIL illegal_num got %h want 2", num[7:4]); end
    checks++; if (evq.size() !== 0) begin errors++; $display("FAIL illegal_evt got %0d want 0", evq.size()); end
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp_ev [3];
    logic [5:0] got;
    exp_ev[0] = {2'd0, 4'h5};
    exp_ev[1] = {2'd3, 4'hA};
    exp_ev[2] = {2'd0, 4'h9};
    do_reset();
    evt_if.evt_ready = 1'b0;
    repeat (3) frame(P5, BL, BL, P7);
    idle(8);
    checks++; if (evt_if.evt_valid !== 1'b1) begin errors++; $display("FAIL bp_offer got %b want 1", evt_if.evt_valid); end
    checks++; if ({evt_if.evt_digit, evt_if.evt_num} !== 6'b00_0101) begin errors++; $display("FAIL bp_first got %h want %h", {evt_if.evt_digit, evt_if.evt_num}, 6'b00_0101); end
    checks++; if (num !== 16'h7005) begin errors++; $display("FAIL bp_num1 got %h want 7005", num); end
    for (int f = 0; f < 17; f++) begin
      frame(P9, BL, BL, PA);
      checks++; if ({evt_if.evt_valid, evt_if.evt_digit, evt_if.evt_num} !== 7'b1_00_0101) begin
        errors++; $display("FAIL bp_frozen%0d got %h want %h", f, {evt_if.evt_valid, evt_if.evt_digit, evt_if.evt_num}, 7'b1_00_0101);
      end
    end
    idle(4);
    checks++; if (num !== 16'hA009) begin errors++; $display("FAIL bp_num2 got %h want A009", num); end
    checks++; if (evq.size() !== 0) begin errors++; $display("FAIL bp_held got %0d want 0", evq.size()); end
    evt_if.evt_ready = 1'b1;
    idle(8);
    checks++; if (evq.size() !== 3) begin errors++; $display("FAIL bp_evt_count got %0d want 3", evq.size()); end
    for (int i = 0; i < 3; i++) begin
      got = (i < evq.size()) ? evq[i] : 6'h3F;
      checks++; if (got !== exp_ev[i]) begin errors++; $display("FAIL bp_evt%0d got %h want %h", i, got, exp_ev[i]); end
    end
    checks++; if (evc.size() !== 3 || evc[1] !== evc[0] + 1 || evc[2] !== evc[1] + 1) begin
      errors++; $display("FAIL bp_b2b got %0d stamps want 3 consecutive", evc.size());
    end
    checks++; if (evt_if.evt_valid !== 1'b0) begin errors++; $display("FAIL bp_drop got %b want 0", evt_if.evt_valid); end
  endtask

  task automatic test_sel_err();
    do_reset();
    drive(4'b0110, P1, 4);
    idle(6);
    checks++; if (sel_err !== 1'b1) begin errors++; $display("FAIL sel_err_set got %b want 1", sel_err); end
    repeat (2) frame(BL, P1, BL, BL);
    idle(6);
    checks++; if (valid_mask[1] !== 1'b0) begin errors++; $display("FAIL sel_no_sample got %b want 0", valid_mask[1]); end
    checks++; if (sel_err !== 1'b1) begin errors++; $display("FAIL sel_err_sticky got %b want 1", sel_err); end
    frame(BL, P1, BL, BL);
    idle(6);
    checks++; if (valid_mask[1] !== 1'b1 || num[7:4] !== 4'h1) begin
      errors++; $display("FAIL sel_commit got %b/%h want 1/1", valid_mask[1], num[7:4]);
    end
    repeat (3) begin
      drive(4'b0001, P1, 1);
      idle(4);
    end
    checks++; if (valid_mask[0] !== 1'b0) begin errors++; $display("FAIL short_strobe got %b want 0", valid_mask[0]); end
    repeat (3) begin
      drive(4'b0001, P1, 2);
      idle(4);
    end
    checks++; if (valid_mask[0] !== 1'b1 || num[3:0] !== 4'h1) begin
      errors++; $display("FAIL settle_strobe got %b/%h want 1/1", valid_mask[0], num[3:0]);
    end
    checks++; if (sel_err !== 1'b1) begin errors++; $display("FAIL sel_err_end got %b want 1", sel_err); end
  endtask

  task automatic test_async_reset();
    do_reset();
    evt_if.evt_ready = 1'b0;
    drive(4'b0011, BL, 4);
    repeat (3) frame(P1, P2, P3, P4);
    idle(4);
    checks++; if (evt_if.evt_valid !== 1'b1 || sel_err !== 1'b1) begin
      errors++; $display("FAIL areset_pre got %b/%b want 1/1", evt_if.evt_valid, sel_err);
    end
    dig_sel = 4'b0001;
    seg     = P1;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++; if (num !== 16'h0 || valid_mask !== 4'h0 || err_mask !== 4'h0) begin
      errors++; $display("FAIL areset_data got %h/%h/%h want 0/0/0", num, valid_mask, err_mask);
    end
    checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL areset_sel got %b want 0", sel_err); end
    checks++; if ({evt_if.evt_valid, evt_if.evt_digit, evt_if.evt_num} !== 7'h00) begin
      errors++; $display("FAIL areset_evt got %h want 00", {evt_if.evt_valid, evt_if.evt_digit, evt_if.evt_num});
    end
    @(negedge clk);
    reset_n = 1'b1;
    evt_if.evt_ready = 1'b1;
    evq.delete();
    evc.delete();
    repeat (2) frame(P1, P2, P3, P4);
    idle(6);
    checks++; if (valid_mask !== 4'h0 || num !== 16'h0) begin
      errors++; $display("FAIL areset_early got %h/%h want 0/0", valid_mask, num);
    end
    frame(P1, P2, P3, P4);
    idle(8);
    checks++; if (valid_mask !== 4'hF || num !== 16'h4321) begin
      errors++; $display("FAIL areset_recover got %h/%h want F/4321", valid_mask, num);
    end
    checks++; if (evq.size() !== 4) begin errors++; $display("FAIL areset_evt_count got %0d want 4", evq.size()); end
  endtask

  initial begin
    evt_if.evt_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_decode_frames();
    test_glitch();
    test_blank_illegal();
    test_back_to_back();
    test_sel_err();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
